// File: rtl/demux1to8_seq_pkg.sv
// Shared constants and helpers for the 1-to-8 sequential demultiplexer.
// The one-hot helper is the inverse of the 8:1 select tree's index.
package demux1to8_seq_pkg;

    localparam int NCH = 8;
    localparam int SELW = 3;
    localparam logic [NCH-1:0] FILL_ALL = 8'hFF;

    function automatic logic [NCH-1:0] onehot3(input logic [SELW-1:0] s);
        return 8'b1 << s;
    endfunction

endpackage

// File: rtl/demux1to8_seq_dec.sv
// Combinational 3-to-8 one-hot decoder with enable.
// The output is all zeros when the enable is low.
module dec3to8
    import demux1to8_seq_pkg::*;
(
    input  logic            en,
    input  logic [SELW-1:0] sel,
    output logic [NCH-1:0]  onehot
);

    assign onehot = en ? onehot3(sel) : '0;

endmodule

// File: rtl/demux1to8_seq.sv
// Registered 1-to-8 demultiplexer. It routes one sample per valid cycle into 8 channel registers.
// A full-frame snapshot and a one-cycle pulse are emitted once all 8 channels have been written.
module demux1to8_seq
    import demux1to8_seq_pkg::*;
#(
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     din,
    input  logic             sel_en,
    input  logic [SELW-1:0]  sel,
    input  logic             clear,
    output logic [NCH*W-1:0] ch_q,
    output logic [NCH-1:0]   ch_strobe,
    output logic [SELW-1:0]  slot,
    output logic [NCH-1:0]   fill,
    output logic [NCH*W-1:0] out_data,
    output logic             out_valid
);

    logic [SELW-1:0]  target;
    logic [NCH-1:0]   onehot;
    logic [NCH-1:0]   next_fill;
    logic [NCH*W-1:0] ch_next;
    logic             wr_en;
    logic             frame_done;

    assign target     = sel_en ? sel : slot;
    assign wr_en      = in_valid & ~clear;
    assign next_fill  = fill | onehot;
    assign frame_done = (next_fill == FILL_ALL);

    dec3to8 u_dec (
        .en     (wr_en),
        .sel    (target),
        .onehot (onehot)
    );

    // The completing sample must land in the snapshot, so merge it before registering.
    always_comb begin
        ch_next = ch_q;
        for (int i = 0; i < NCH; i++) begin
            if (onehot[i]) ch_next[i*W +: W] = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q      <= '0;
            out_data  <= '0;
            ch_strobe <= '0;
            fill      <= '0;
            slot      <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            slot      <= '0;
            fill      <= '0;
            ch_strobe <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            ch_q      <= ch_next;
            ch_strobe <= onehot;
            slot      <= target + 3'd1;
            if (frame_done) begin
                out_data  <= ch_next;
                out_valid <= 1'b1;
                fill      <= '0;
            end else begin
                fill      <= next_fill;
                out_valid <= 1'b0;
            end
        end else begin
            ch_strobe <= '0;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_demux1to8_seq.sv
// Self-checking bench for demux1to8_seq (W=4): a table of vectors, hand-written corner sequences,
// and random traffic compared against an array-based reference model.
module tb_demux1to8_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic [W-1:0]   din;
    logic           sel_en;
    logic [2:0]     sel;
    logic           clear;
    logic [8*W-1:0] ch_q;
    logic [7:0]     ch_strobe;
    logic [2:0]     slot;
    logic [7:0]     fill;
    logic [8*W-1:0] out_data;
    logic           out_valid;

    int checks = 0;
    int errors = 0;

    demux1to8_seq #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .din       (din),
        .sel_en    (sel_en),
        .sel       (sel),
        .clear     (clear),
        .ch_q      (ch_q),
        .ch_strobe (ch_strobe),
        .slot      (slot),
        .fill      (fill),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel arrays plus a "written this frame" set.
    logic [W-1:0] m_ch[8];
    logic [W-1:0] m_snap[8];
    bit           m_wr[8];
    int           m_slot;
    logic [7:0]   m_strobe;
    logic         m_valid;

    typedef struct {
        logic       iv;
        logic       se;
        logic [2:0] sl;
        logic       clr;
        logic [3:0] d;
        logic [7:0] strobe;
        logic [2:0] slot;
        logic [7:0] fill;
        logic       ov;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [8*W-1:0] pack(input logic [W-1:0] a[8]);
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*W +: W] = a[i];
        return v;
    endfunction

    function automatic logic [7:0] m_fill();
        logic [7:0] f;
        for (int i = 0; i < 8; i++) f[i] = m_wr[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_ch[i]   = '0;
            m_snap[i] = '0;
            m_wr[i]   = 1'b0;
        end
        m_slot   = 0;
        m_strobe = '0;
        m_valid  = 1'b0;
    endtask

    task automatic model_edge();
        int t;
        int n;
        if (clear) begin
            m_slot   = 0;
            m_strobe = '0;
            m_valid  = 1'b0;
            for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
        end else if (in_valid) begin
            t = sel_en ? int'(sel) : m_slot;
            m_ch[t]  = din;
            m_strobe = 8'(1 << t);
            m_slot   = (t + 1) % 8;
            m_wr[t]  = 1'b1;
            n = 0;
            for (int i = 0; i < 8; i++) if (m_wr[i]) n++;
            if (n == 8) begin
                m_snap  = m_ch;
                m_valid = 1'b1;
                for (int i = 0; i < 8; i++) m_wr[i] = 1'b0;
            end else begin
                m_valid = 1'b0;
            end
        end else begin
            m_strobe = '0;
            m_valid  = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".ch_q"},      64'(ch_q),      64'(pack(m_ch)));
        check({tag, ".strobe"},    64'(ch_strobe), 64'(m_strobe));
        check({tag, ".slot"},      64'(slot),      64'(m_slot));
        check({tag, ".fill"},      64'(fill),      64'(m_fill()));
        check({tag, ".out_data"},  64'(out_data),  64'(pack(m_snap)));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    endtask

    task automatic drive(input logic iv, input logic se, input logic [2:0] sl,
                         input logic clr, input logic [W-1:0] d);
        in_valid = iv;
        sel_en   = se;
        sel      = sl;
        clear    = clr;
        din      = d;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [7:0] bit0_of_frame(input logic [8*W-1:0] v);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = v[i*W];
        return b;
    endfunction

    initial begin
        logic [8*W-1:0] saved;
        int             nvalid;
        logic [7:0]     t1d;

        // Test 1 (auto fill) then test 2 (explicit select followed by auto).
        t1d = 8'b0100_1101;
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{iv: 1'b1, se: 1'b0, sl: 3'd0, clr: 1'b0, d: 4'(t1d[i]),
                       strobe: 8'(1 << i), slot: 3'((i + 1) % 8),
                       fill: (i == 7) ? 8'h00 : 8'((1 << (i + 1)) - 1), ov: (i == 7)};
        end
        tbl[8] = '{iv: 1'b1, se: 1'b1, sl: 3'd5, clr: 1'b0, d: 4'hA,
                   strobe: 8'h20, slot: 3'd6, fill: 8'h20, ov: 1'b0};
        tbl[9] = '{iv: 1'b1, se: 1'b0, sl: 3'd0, clr: 1'b0, d: 4'h3,
                   strobe: 8'h40, slot: 3'd7, fill: 8'h60, ov: 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 1'b0, '0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_model("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].se, tbl[i].sl, tbl[i].clr, tbl[i].d);
            step();
            check($sformatf("tbl%0d.strobe", i), 64'(ch_strobe), 64'(tbl[i].strobe));
            check($sformatf("tbl%0d.slot", i),   64'(slot),      64'(tbl[i].slot));
            check($sformatf("tbl%0d.fill", i),   64'(fill),      64'(tbl[i].fill));
            check($sformatf("tbl%0d.valid", i),  64'(out_valid), 64'(tbl[i].ov));
            check_model($sformatf("tbl%0d", i));
            if (i == 7) check("t1.frame_bits", 64'(bit0_of_frame(out_data)), 64'h4D);
        end
        check("t2.ch5", 64'(ch_q[23:20]), 64'hA);
        check("t2.ch6", 64'(ch_q[27:24]), 64'h3);

        // Test 3: duplicate write to channel 2 does not advance completion.
        drive(1'b1, 1'b0, 3'd0, 1'b1, '0);
        step();
        check_model("t3.clr");
        nvalid = 0;
        drive(1'b1, 1'b1, 3'd2, 1'b0, 4'h1);
        step();
        nvalid += out_valid;
        drive(1'b1, 1'b1, 3'd2, 1'b0, 4'h0);
        step();
        nvalid += out_valid;
        check("t3.fill_dup", 64'(fill), 64'h04);
        for (int c = 0; c < 8; c++) begin
            if (c == 2) continue;
            drive(1'b1, 1'b1, 3'(c), 1'b0, 4'($urandom_range(1, 15)));
            step();
            check_model($sformatf("t3.c%0d", c));
            if (c != 7) nvalid += out_valid;
        end
        check("t3.early_valid", 64'(nvalid), 64'd0);
        check("t3.done", 64'(out_valid), 64'd1);
        check("t3.ch2", 64'(out_data[11:8]), 64'h0);

        // Test 4: clear together with a write drops the sample.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 4'($urandom));
            step();
        end
        saved = ch_q;
        drive(1'b1, 1'b0, 3'd0, 1'b1, 4'h1);
        step();
        check("t4.slot", 64'(slot), 64'd0);
        check("t4.fill", 64'(fill), 64'd0);
        check("t4.ch_q", 64'(ch_q), 64'(saved));
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 4'($urandom));
            step();
            nvalid += out_valid;
            check_model($sformatf("t4.w%0d", i));
        end
        check("t4.nvalid", 64'(nvalid), 64'd1);

        // Test 5: asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 4'($urandom_range(1, 15)));
            step();
        end
        drive(1'b0, 1'b0, 3'd0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model("t5.async");
        #2 rst_n = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 4'($urandom));
            step();
            nvalid += out_valid;
        end
        check("t5.nvalid", 64'(nvalid), 64'd1);
        check_model("t5.end");

        // Test 6: streaming, one frame every 8 writes with no bubble.
        nvalid = 0;
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 1'b0, 3'd0, 1'b0, 4'($urandom));
            step();
            check($sformatf("t6.valid%0d", i), 64'(out_valid), 64'((i % 8) == 7));
            check($sformatf("t6.slot%0d", i),  64'(slot),      64'((i + 1) % 8));
            nvalid += out_valid;
        end
        check("t6.nvalid", 64'(nvalid), 64'd3);
        check_model("t6.end");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                  3'($urandom), 1'($urandom_range(0, 19) == 0), 4'($urandom));
            step();
            check_model($sformatf("rnd%0d", i));
        end

        drive(1'b0, 1'b0, 3'd0, 1'b0, '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
